// File: rtl/bram_stream_fifo.sv
// bram_stream_fifo: block-RAM FIFO with first-word-fall-through output.
// RAM -> prefetch register -> output register, one word per cycle.
module bram_stream_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 1024,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH - 1);
  localparam int UW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-2];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  pf_valid;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [UW-1:0]         ram_used;
  logic [CW-1:0]         count_nxt;
  logic                  full;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  out_free;
  logic                  move;
  logic                  ram_rd_en;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 2)) ? '0 : p + PW'(1);
  endfunction

  // handshakes, prefetch control and next occupancy
  always_comb begin
    full      = (count == CW'(DEPTH));
    wr_ready  = ~full & ~flush;
    wr_fire   = wr_valid & wr_ready;
    rd_fire   = rd_valid & rd_ready;
    out_free  = ~rd_valid | rd_ready;
    move      = pf_valid & out_free;
    ram_rd_en = (ram_used != '0) & (~pf_valid | move);
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else
      count_nxt = count + CW'(wr_fire) - CW'(rd_fire);
  end

  // RAM array: no reset so it maps onto a block RAM
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_ptr] <= wr_data;
    if (ram_rd_en)
      ram_q <= mem[rd_ptr];
  end

  // pointers, prefetch/output stages, count and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_used     <= '0;
      count        <= '0;
      pf_valid     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      overflow     <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_nxt;
      almost_full  <= int'(count_nxt) >= AFULL_THRESH;
      almost_empty <= int'(count_nxt) <= AEMPTY_THRESH;
      if (wr_valid & full & ~flush)
        overflow <= 1'b1;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        ram_used <= '0;
        pf_valid <= 1'b0;
        rd_valid <= 1'b0;
      end else begin
        if (wr_fire)
          wr_ptr <= ptr_inc(wr_ptr);
        if (ram_rd_en)
          rd_ptr <= ptr_inc(rd_ptr);
        ram_used <= ram_used + UW'(wr_fire)
                  - UW'(ram_rd_en);
        if (ram_rd_en)
          pf_valid <= 1'b1;
        else if (move)
          pf_valid <= 1'b0;
        if (move) begin
          rd_data  <= ram_q;
          rd_valid <= 1'b1;
        end else if (rd_fire) begin
          rd_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_fifo.sv
// tb_bram_stream_fifo: directed steps with a scoreboard queue.
// Words are pushed when written and popped at each read handshake.
module tb_bram_stream_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = '0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] q[$];

  bram_stream_fifo #(
    .DATA_WIDTH(8),
    .DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .count(count),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int k = 0; k < 30 && q.size() != 0; k++)
      tick();
    chk("drain_done", q.size(), 0);
  endtask

  // scoreboard: every read handshake must match the queue head
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      n_chk++;
      assert (q.size() != 0) n_pass++;
      else $error("FAIL rd_extra: observed %0h expected none",
                  rd_data);
      if (q.size() != 0)
        chk("rd_data", rd_data, q.pop_front());
    end
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_wr_ready", wr_ready, 1);

    // fill to full with reads stalled
    for (int i = 1; i <= 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      q.push_back(8'(i));
      tick();
      chk("fill_count", count, i);
      chk("fill_afull", almost_full, i >= 4);
      chk("fill_aempty", almost_empty, i <= 4);
      chk("fill_wr_ready", wr_ready, i < 8);
      chk("fill_rd_valid", rd_valid, i >= 3);
      if (i == 3)
        chk("fwft_first", rd_data, 8'h01);
    end

    // write while full: dropped, overflow sticks
    wr_data = 8'hAA;
    tick();
    wr_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    tick();
    chk("ovf_sticky", overflow, 1);
    drain();
    chk("drained_count", count, 0);
    chk("drained_valid", rd_valid, 0);
    chk("drained_aempty", almost_empty, 1);

    // continuous streaming across pointer wraps
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      q.push_back(8'(i));
      tick();
      chk("stream_count", count, (i < 2) ? i + 1 : 3);
      if (i >= 2)
        chk("stream_valid", rd_valid, 1);
    end
    wr_valid = 1'b0;
    drain();

    // backpressure: rd_ready 1,0,0,1
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h10 + 8'(i);
      q.push_back(8'h10 + 8'(i));
      tick();
    end
    wr_valid = 1'b0;
    tick();
    tick();
    chk("bp_head", rd_data, q[0]);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    tick();
    chk("bp_hold1", rd_data, q[0]);
    chk("bp_valid1", rd_valid, 1);
    tick();
    chk("bp_hold2", rd_data, q[0]);
    chk("bp_count", count, 2);
    rd_ready = 1'b1;
    tick();
    drain();

    // flush with 5 words buffered and a write pending
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h30 + 8'(i);
      q.push_back(8'h30 + 8'(i));
      tick();
    end
    chk("pre_flush_count", count, 5);
    flush    = 1'b1;
    wr_data  = 8'h77;
    #1;
    chk("flush_wr_ready", wr_ready, 0);
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    q.delete();
    chk("flush_count", count, 0);
    chk("flush_valid", rd_valid, 0);
    chk("flush_ovf_kept", overflow, 1);
    chk("flush_aempty", almost_empty, 1);
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    q.push_back(8'h55);
    tick();
    wr_valid = 1'b0;
    tick();
    chk("post_flush_lat", rd_valid, 0);
    tick();
    chk("post_flush_valid", rd_valid, 1);
    chk("post_flush_data", rd_data, 8'h55);
    drain();

    // reset in the middle of traffic
    rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h60 + 8'(i);
      q.push_back(8'h60 + 8'(i));
      tick();
    end
    chk("pre_rst_count", count, 6);
    chk("pre_rst_ovf", overflow, 1);
    rst      = 1'b1;
    rd_ready = 1'b1;
    wr_data  = 8'h99;
    tick();
    rst      = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    q.delete();
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_valid", rd_valid, 0);
    chk("mrst_wr_ready", wr_ready, 1);
    chk("mrst_aempty", almost_empty, 1);
    chk("mrst_afull", almost_full, 0);
    chk("mrst_rd_data", rd_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
